decoder_seq: RTL and testbench
==============================

Name: decoder_seq

Overview:
- Parametrised, registered N-to-2^N one-hot decoder with enable and a valid/ready input handshake.
- Adds a SCAN mode. An FSM walks the one-hot output across consecutive indices, wrapping at the top. Used for row/channel select sequencing.
- Sits between the control logic issuing select codes and the downstream strobe/select lines.

Parameters:
- IN_W, 3, select code width
- OUT_W, 2**IN_W, output line count (derived; do not override)
- CNT_W, IN_W+1, width of scan length field; must hold values 1..OUT_W

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  request valid
- in_ready  output  1  block can accept a request
- mode  input  1  0 = DIRECT, 1 = SCAN; sampled on accept
- din  input  IN_W  select code / scan start index
- en  input  1  output enable; sampled on accept
- scan_len  input  CNT_W  number of scan steps; sampled on accept
- dout  output  OUT_W  registered one-hot (or all-zero) select
- dout_valid  output  1  dout holds a decoded value this cycle
- scan_done  output  1  one-cycle pulse with the last scan step

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high.
- Reset values: dout=0, dout_valid=0, scan_done=0, in_ready=1; FSM=IDLE.
- Accept: a request is accepted on a rising clk edge when in_valid && in_ready.
- FSM states IDLE, SCAN. in_ready=1 only in IDLE.
- DIRECT accept (mode=0), latency 1 cycle:
  - Next cycle: dout = en ? (1<<din) : 0; dout_valid=1.
  - Stays in IDLE, so back-to-back accepts give one output per cycle.
- SCAN accept (mode=1, en=1, scan_len>=1):
  - Go to SCAN. Load idx=din, remaining=scan_len.
  - Each cycle in SCAN: dout=1<<idx, dout_valid=1, idx=idx+1 mod OUT_W (wrap OUT_W-1 -> 0), remaining decrements.
  - When the output step has remaining==1: scan_done=1 in that same cycle; next state IDLE.
  - Total steps = scan_len. First step appears 1 cycle after accept.
- SCAN with en=0 or scan_len==0: treated as DIRECT with en=0. dout=0 and dout_valid=1 for one cycle; no FSM transition; scan_done=0.
- scan_len > OUT_W is legal: indices repeat after wrap.
- Idle cycles with no accept: dout=0, dout_valid=0. Outputs are not held.
- Inputs other than in_valid are ignored while in SCAN. in_valid may stay high; it is accepted on the first IDLE cycle.
- Reset mid-scan: next cycle is reset state; no scan_done pulse.
- Back-to-back scan: a new request can be accepted in the cycle after scan_done, since in_ready returns to 1 in IDLE that cycle.

Optional Feature:
- Macro: DECODER_SEQ_ONEHOT_CHECK_EN.
- Defined: adds output onehot_err (1 bit, reset 0). Registered; asserts one cycle after dout has more than one bit set, or has zero bits set while dout_valid=1 and en was 1 at accept.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package decoder_seq_pkg:
  - mode enum (MODE_DIRECT=0, MODE_SCAN=1)
  - FSM state enum (ST_IDLE, ST_SCAN)
  - localparam helper for OUT_W from IN_W
- Sub-module decoder_onehot: purely combinational IN_W -> OUT_W one-hot with enable. Instantiated once, fed by the idx/din mux.
- Register, FSM and handshake logic live in decoder_seq.

Test Plan:
- Reset then DIRECT din=5, en=1 -> next cycle dout=8'b0010_0000, dout_valid=1; the cycle after, dout=0, dout_valid=0.
- DIRECT back-to-back din=0,7,3 with en=1,0,1 -> dout=0x01, 0x00 (dout_valid=1), 0x08 on consecutive cycles; in_ready stays 1.
- SCAN din=6, scan_len=4, en=1 -> dout sequence 0x40, 0x80, 0x01, 0x02; scan_done high with 0x02; in_ready=0 for those 4 cycles.
- SCAN scan_len=0 (and separately en=0) -> dout=0, dout_valid=1 for one cycle; scan_done=0; in_ready never drops.
- SCAN din=2, scan_len=8, rst asserted on 3rd step -> reset values next cycle, no scan_done; a new DIRECT din=1 is accepted the following cycle -> dout=0x02.
- With DECODER_SEQ_ONEHOT_CHECK_EN, sweep all 8 codes in both modes -> onehot_err stays 0.

Source files
------------

// File: rtl/decoder_seq_pkg.sv
// Shared types and sizing helpers for the decoder_seq select sequencer.
package decoder_seq_pkg;

  // Request mode carried on the mode input.
  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  // Sequencer FSM: IDLE accepts requests, SCAN walks the one-hot output.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

  // Default select code width.
  localparam int DEFAULT_IN_W = 3;

  // Number of output lines for a given select code width.
  function automatic int out_w_of(input int in_w);
    return 1 << in_w;
  endfunction

endpackage

// File: rtl/decoder_onehot.sv
// Combinational IN_W -> 2**IN_W one-hot decoder with enable.
// With en low the output is all-zero.
module decoder_onehot #(
  parameter int IN_W  = 3,
  parameter int OUT_W = 2 ** IN_W
) (
  input  logic [IN_W-1:0]  sel,
  input  logic             en,
  output logic [OUT_W-1:0] onehot
);

  // Drive the selected line when enabled, all others low.
  always_comb begin
    // NOTE: default every combinational output first so no path leaves it unassigned (no latch).
    onehot = '0;
    if (en) begin
      onehot[sel] = 1'b1;
    end
  end

endmodule

// File: rtl/decoder_seq.sv
// Registered one-hot decoder with valid/ready request handshake and a SCAN
// mode that walks the select line across consecutive indices (wrapping).
// Optional build macro DECODER_SEQ_ONEHOT_CHECK_EN adds the onehot_err output,
// a registered flag raised one cycle after dout is not a legal one-hot value.
module decoder_seq
  import decoder_seq_pkg::*;
#(
  parameter int IN_W  = DEFAULT_IN_W,
  parameter int OUT_W = out_w_of(IN_W),
  parameter int CNT_W = IN_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [IN_W-1:0]  din,
  input  logic             en,
  input  logic [CNT_W-1:0] scan_len,
  output logic [OUT_W-1:0] dout,
  output logic             dout_valid,
  output logic             scan_done
`ifdef DECODER_SEQ_ONEHOT_CHECK_EN
  ,
  output logic             onehot_err
`endif
);

  state_e           state, state_d;
  logic [IN_W-1:0]  idx, idx_d;     // index currently shown during SCAN
  logic [CNT_W-1:0] rem, rem_d;     // steps left including the one shown
  logic [OUT_W-1:0] dout_d;
  logic             dout_valid_d;
  logic             scan_done_d;

  logic             accept;
  logic             scan_start;
  logic             req_hot;        // request should produce a set bit
  logic [IN_W-1:0]  idx_next;
  logic [IN_W-1:0]  dec_sel;
  logic             dec_en;
  logic [OUT_W-1:0] dec_out;

  assign in_ready = (state == ST_IDLE);
  assign accept   = in_valid && in_ready;

  // A SCAN request with en low or zero length degrades to a disabled DIRECT.
  assign scan_start = (mode_e'(mode) == MODE_SCAN) && en && (scan_len != '0);
  assign req_hot    = en && !((mode_e'(mode) == MODE_SCAN) && (scan_len == '0));

  // Natural IN_W-bit overflow gives the OUT_W-1 -> 0 wrap.
  assign idx_next = idx + IN_W'(1);

  // In SCAN the decoder prepares the next step; in IDLE it decodes the request.
  assign dec_sel = (state == ST_SCAN) ? idx_next : din;
  assign dec_en  = (state == ST_SCAN) ? 1'b1 : req_hot;

  decoder_onehot #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_onehot (
    .sel    (dec_sel),
    .en     (dec_en),
    .onehot (dec_out)
  );

  // Next-state and next-output logic; outputs return to zero when nothing is presented.
  always_comb begin
    state_d      = state;
    idx_d        = idx;
    rem_d        = rem;
    dout_d       = '0;
    dout_valid_d = 1'b0;
    scan_done_d  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          dout_d       = dec_out;
          dout_valid_d = 1'b1;
          if (scan_start) begin
            state_d     = ST_SCAN;
            idx_d       = din;
            rem_d       = scan_len;
            scan_done_d = (scan_len == CNT_W'(1));
          end
        end
      end
      ST_SCAN: begin
        if (rem != CNT_W'(1)) begin
          dout_d       = dec_out;
          dout_valid_d = 1'b1;
          idx_d        = idx_next;
          rem_d        = rem - CNT_W'(1);
          scan_done_d  = (rem == CNT_W'(2));
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Output and scan-position registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= '0;
      rem        <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      scan_done  <= 1'b0;
    end else begin
      idx        <= idx_d;
      rem        <= rem_d;
      dout       <= dout_d;
      dout_valid <= dout_valid_d;
      scan_done  <= scan_done_d;
    end
  end

`ifdef DECODER_SEQ_ONEHOT_CHECK_EN
  logic hot_q;      // dout currently shown was expected to carry one set bit
  logic multi_hot;

  assign multi_hot = (dout & (dout - OUT_W'(1))) != '0;

  // Flag a multi-hot dout, or an empty dout where a set bit was expected.
  always_ff @(posedge clk) begin
    if (rst) begin
      hot_q      <= 1'b0;
      onehot_err <= 1'b0;
    end else begin
      hot_q      <= dout_valid_d && dec_en;
      onehot_err <= multi_hot || ((dout == '0) && dout_valid && hot_q);
    end
  end
`endif

endmodule

// File: tb/tb_decoder_seq.sv
// Scoreboard bench for decoder_seq: stimulus pushes hand-computed expected
// outputs, a negedge monitor pops and compares whenever dout_valid is high.
module tb_decoder_seq;
  import decoder_seq_pkg::*;

  localparam int IN_W  = 3;
  localparam int OUT_W = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic             mode;
  logic [IN_W-1:0]  din;
  logic             en;
  logic [CNT_W-1:0] scan_len;
  logic [OUT_W-1:0] dout;
  logic             dout_valid;
  logic             scan_done;
`ifdef DECODER_SEQ_ONEHOT_CHECK_EN
  logic             onehot_err;
`endif

  typedef struct {
    logic [OUT_W-1:0] dout;
    logic             done;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic mon_en = 1'b0;

  decoder_seq #(
    .IN_W  (IN_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mode       (mode),
    .din        (din),
    .en         (en),
    .scan_len   (scan_len),
    .dout       (dout),
    .dout_valid (dout_valid),
    .scan_done  (scan_done)
`ifdef DECODER_SEQ_ONEHOT_CHECK_EN
    ,
    .onehot_err (onehot_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [OUT_W-1:0] d, input logic done);
    exp_t e;
    e.dout = d;
    e.done = done;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request and hold it until an edge where in_ready was high.
  task automatic send(input mode_e m, input logic [IN_W-1:0] d, input logic e,
                      input logic [CNT_W-1:0] len);
    logic accepted;
    accepted = 1'b0;
    in_valid = 1'b1;
    mode     = m;
    din      = d;
    en       = e;
    scan_len = len;
    for (int i = 0; i < 50 && !accepted; i++) begin
      if (in_ready) accepted = 1'b1;
      step();
    end
    check("send_accept", accepted, 1);
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // Monitor: compare each presented output against the scoreboard head.
  always @(negedge clk) begin
    if (mon_en) begin
      if (dout_valid) begin
        check("sb_has_entry", (sb.size() > 0), 1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          check("dout", dout, e.dout);
          check("scan_done", scan_done, e.done);
        end
      end else begin
        check("idle_outputs", {dout, scan_done}, 0);
      end
`ifdef DECODER_SEQ_ONEHOT_CHECK_EN
      check("onehot_err", onehot_err, 0);
`endif
    end
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    mode     = 1'b0;
    din      = '0;
    en       = 1'b0;
    scan_len = '0;
    step();
    step();
    check("rst_dout", dout, 0);
    check("rst_dout_valid", dout_valid, 0);
    check("rst_scan_done", scan_done, 0);
    check("rst_in_ready", in_ready, 1);
    rst    = 1'b0;
    mon_en = 1'b1;

    // DIRECT din=5 then an idle cycle.
    push(8'h20, 1'b0);
    send(MODE_DIRECT, 3'd5, 1'b1, 4'd0);
    idle();
    step();
    step();

    // DIRECT back-to-back with en=1,0,1.
    push(8'h01, 1'b0);
    push(8'h00, 1'b0);
    push(8'h08, 1'b0);
    send(MODE_DIRECT, 3'd0, 1'b1, 4'd0);
    check("b2b_ready0", in_ready, 1);
    send(MODE_DIRECT, 3'd7, 1'b0, 4'd0);
    check("b2b_ready1", in_ready, 1);
    send(MODE_DIRECT, 3'd3, 1'b1, 4'd0);
    check("b2b_ready2", in_ready, 1);
    idle();
    step();
    step();

    // SCAN din=6 len=4 wraps 7 -> 0.
    push(8'h40, 1'b0);
    push(8'h80, 1'b0);
    push(8'h01, 1'b0);
    push(8'h02, 1'b1);
    send(MODE_SCAN, 3'd6, 1'b1, 4'd4);
    idle();
    for (int i = 0; i < 4; i++) begin
      check("scan_busy", in_ready, 0);
      step();
    end
    check("scan_ready_back", in_ready, 1);
    step();

    // Degenerate SCAN requests: zero length, then en low.
    push(8'h00, 1'b0);
    push(8'h00, 1'b0);
    send(MODE_SCAN, 3'd3, 1'b1, 4'd0);
    check("len0_ready", in_ready, 1);
    send(MODE_SCAN, 3'd3, 1'b0, 4'd5);
    check("en0_ready", in_ready, 1);
    idle();
    step();
    step();

    // SCAN len=2 followed by a waiting DIRECT; changed inputs ignored during SCAN.
    push(8'h80, 1'b0);
    push(8'h01, 1'b1);
    push(8'h10, 1'b0);
    send(MODE_SCAN, 3'd7, 1'b1, 4'd2);
    send(MODE_DIRECT, 3'd4, 1'b1, 4'd0);
    idle();
    step();
    step();

    // scan_len larger than OUT_W repeats indices after the wrap.
    for (int i = 0; i < 10; i++) push(8'h01 << (i % 8), (i == 9));
    send(MODE_SCAN, 3'd0, 1'b1, 4'd10);
    idle();
    repeat (11) step();

    // Reset during the third step of a long scan.
    push(8'h04, 1'b0);
    push(8'h08, 1'b0);
    push(8'h10, 1'b0);
    send(MODE_SCAN, 3'd2, 1'b1, 4'd8);
    idle();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstmid_ready", in_ready, 1);
    check("rstmid_done", scan_done, 0);
    push(8'h02, 1'b0);
    send(MODE_DIRECT, 3'd1, 1'b1, 4'd0);
    idle();
    step();
    step();

    // Sweep every code in both modes.
    for (int i = 0; i < 8; i++) begin
      push(8'h01 << i, 1'b0);
      send(MODE_DIRECT, 3'(i), 1'b1, 4'd0);
    end
    for (int i = 0; i < 8; i++) begin
      push(8'h01 << i, 1'b1);
      send(MODE_SCAN, 3'(i), 1'b1, 4'd1);
    end
    idle();
    repeat (4) step();

    check("sb_drained", sb.size(), 0);
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
